// File: rtl/if_resp.sv
// Instruction-fetch responder. It issues one registered req/ack read per fetch
// and hands the word to IF/ID. It drops stale data after a flush and returns
// a NOP on a misaligned fetch or a bus timeout.
// Ports:
//   clk, rst            clock, sync active-high reset
//   pc_i, ce_i          fetch address and fetch enable
//   flush_i, stall_i    branch flush and downstream stall
//   mem_req_o/addr_o    read request to instruction memory
//   mem_ack_i/data_i    memory acknowledge and read data
//   inst_o/addr_o/valid instruction bundle to IF/ID
//   busy_o              stall request while a read is outstanding
//   misalign_o, err_o   single-cycle event pulses
module if_resp #(
  parameter int          ADDR_W   = 32,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic              flush_i,
  input  logic              stall_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_valid_o,
  output logic              busy_o,
  output logic              misalign_o,
  output logic              err_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t            r_state, w_state;
  logic              r_req, w_req;
  logic [ADDR_W-1:0] r_maddr, w_maddr;
  logic [31:0]       r_inst, w_inst;
  logic [ADDR_W-1:0] r_iaddr, w_iaddr;
  logic              r_valid, w_valid;
  logic              r_busy, w_busy;
  logic              r_mis, w_mis;
  logic              r_err, w_err;
  logic              r_drop, w_drop;
  logic [CW-1:0]     r_cnt, w_cnt;
  logic [31:0]       r_skid, w_skid;
  logic              w_hs;

  // An ack only counts while a request is actually on the bus.
  assign w_hs = r_req & mem_ack_i;

  always_comb begin
    w_state = r_state;
    w_req   = r_req;
    w_maddr = r_maddr;
    w_inst  = r_inst;
    w_iaddr = r_iaddr;
    w_valid = r_valid;
    w_busy  = r_busy;
    w_mis   = 1'b0;
    w_err   = 1'b0;
    w_drop  = r_drop;
    w_cnt   = r_cnt;
    w_skid  = r_skid;
    unique case (r_state)
      S_IDLE: begin
        if (flush_i) begin
          w_valid = 1'b0;
        end else if (ce_i && !stall_i) begin
          if (pc_i[1:0] != 2'b00) begin
            w_inst  = NOP_INST;
            w_iaddr = pc_i;
            w_valid = 1'b1;
            w_mis   = 1'b1;
          end else begin
            w_req   = 1'b1;
            w_maddr = pc_i;
            w_busy  = 1'b1;
            w_cnt   = '0;
            w_drop  = 1'b0;
            w_valid = 1'b0;
            w_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A flush never abandons the bus; it only marks the data stale.
        if (flush_i) begin
          w_drop  = 1'b1;
          w_valid = 1'b0;
        end
        if (w_hs) begin
          w_req = 1'b0;
          if (r_drop || flush_i) begin
            w_busy  = 1'b0;
            w_valid = 1'b0;
            w_state = S_IDLE;
          end else if (!stall_i) begin
            w_inst  = mem_data_i;
            w_iaddr = r_maddr;
            w_valid = 1'b1;
            w_busy  = 1'b0;
            w_state = S_IDLE;
          end else begin
            w_skid  = mem_data_i;
            w_state = S_HOLD;
          end
        end else if (r_cnt == CMAX) begin
          w_req   = 1'b0;
          w_busy  = 1'b0;
          w_err   = 1'b1;
          w_inst  = NOP_INST;
          w_iaddr = r_maddr;
          w_valid = ~(r_drop | flush_i);
          w_state = S_IDLE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (flush_i) begin
          w_valid = 1'b0;
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end else if (!stall_i) begin
          w_inst  = r_skid;
          w_iaddr = r_maddr;
          w_valid = 1'b1;
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_maddr <= '0;
      r_inst  <= NOP_INST;
      r_iaddr <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_mis   <= 1'b0;
      r_err   <= 1'b0;
      r_drop  <= 1'b0;
      r_cnt   <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state;
      r_req   <= w_req;
      r_maddr <= w_maddr;
      r_inst  <= w_inst;
      r_iaddr <= w_iaddr;
      r_valid <= w_valid;
      r_busy  <= w_busy;
      r_mis   <= w_mis;
      r_err   <= w_err;
      r_drop  <= w_drop;
      r_cnt   <= w_cnt;
      r_skid  <= w_skid;
    end
  end

  assign mem_req_o    = r_req;
  assign mem_addr_o   = r_maddr;
  assign inst_o       = r_inst;
  assign inst_addr_o  = r_iaddr;
  assign inst_valid_o = r_valid;
  assign busy_o       = r_busy;
  assign misalign_o   = r_mis;
  assign err_o        = r_err;

endmodule

// File: tb/tb_if_resp.sv
// Bench for if_resp: directed fetches then random fetch transactions,
// each checked against a transaction-level expectation model.
module tb_if_resp;

  localparam int          TO  = 16;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = '0;
  logic        ce_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_data_i = '0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic        busy_o;
  logic        misalign_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_inst;
  logic [31:0] m_addr;
  logic        m_valid;

  always #5 clk = ~clk;

  if_resp #(.ADDR_W(32), .TIMEOUT(TO), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i),
    .flush_i(flush_i), .stall_i(stall_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .inst_valid_o(inst_valid_o), .busy_o(busy_o),
    .misalign_o(misalign_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag);
    chk({tag, ".inst"}, inst_o, m_inst);
    chk({tag, ".iaddr"}, inst_addr_o, m_addr);
    chk({tag, ".valid"}, {31'b0, inst_valid_o}, {31'b0, m_valid});
  endtask

  task automatic chk_ctl(input string tag, input bit req, input bit busy,
                         input bit mis, input bit err);
    chk({tag, ".req"}, {31'b0, mem_req_o}, {31'b0, req});
    chk({tag, ".busy"}, {31'b0, busy_o}, {31'b0, busy});
    chk({tag, ".mis"}, {31'b0, misalign_o}, {31'b0, mis});
    chk({tag, ".err"}, {31'b0, err_o}, {31'b0, err});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    ce_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
    mem_ack_i = 1'($urandom); mem_data_i = $urandom;
    step();
    chk_ctl({tag, ".idle"}, 0, 0, 0, 0);
    chk_out({tag, ".idle"});
  endtask

  // One fetch transaction.
  // lat: req cycles until ack (lat > TO means the memory never answers)
  // fl:  WAIT cycle carrying a flush pulse (0 = none)
  // st:  stall cycles starting at the ack cycle
  // hfl: leave the hold with a flush instead of a release
  task automatic fetch(input string tag, input logic [31:0] a,
                       input int lat, input logic [31:0] d,
                       input int fl, input int st, input bit hfl);
    bit to, stale;
    int endc;
    @(negedge clk);
    pc_i = a; ce_i = 1'b1; stall_i = 1'b0;
    flush_i = 1'b0; mem_ack_i = 1'b0;
    step();
    if (a[1:0] != 2'b00) begin
      m_inst = NOP; m_addr = a; m_valid = 1'b1;
      chk_ctl({tag, ".mis"}, 0, 0, 1, 0);
      chk_out({tag, ".mis"});
      idle_cycle(tag);
      return;
    end
    m_valid = 1'b0;
    chk_ctl({tag, ".req"}, 1, 1, 0, 0);
    chk({tag, ".maddr"}, mem_addr_o, a);
    chk_out({tag, ".req"});
    to = lat > TO;
    endc = to ? TO : lat;
    stale = fl >= 1 && fl <= endc;
    for (int i = 1; i <= endc; i++) begin
      @(negedge clk);
      ce_i = 1'b0;
      mem_ack_i = !to && i == endc;
      mem_data_i = mem_ack_i ? d : $urandom;
      flush_i = i == fl;
      stall_i = !to && i == endc && st > 0;
      step();
      if (i < endc) begin
        chk_ctl({tag, ".wait"}, 1, 1, 0, 0);
        chk({tag, ".wmaddr"}, mem_addr_o, a);
        chk_out({tag, ".wait"});
      end
    end
    if (to) begin
      m_inst = NOP; m_addr = a; m_valid = !stale;
      chk_ctl({tag, ".to"}, 0, 0, 0, 1);
      chk_out({tag, ".to"});
    end else if (stale) begin
      chk_ctl({tag, ".stale"}, 0, 0, 0, 0);
      chk_out({tag, ".stale"});
    end else if (st == 0) begin
      m_inst = d; m_addr = a; m_valid = 1'b1;
      chk_ctl({tag, ".ack"}, 0, 0, 0, 0);
      chk_out({tag, ".ack"});
    end else begin
      chk_ctl({tag, ".hold"}, 0, 1, 0, 0);
      chk_out({tag, ".hold"});
      for (int j = 1; j < st; j++) begin
        @(negedge clk);
        flush_i = 1'b0; stall_i = 1'b1;
        mem_ack_i = 1'($urandom); mem_data_i = $urandom;
        step();
        chk_ctl({tag, ".holdn"}, 0, 1, 0, 0);
        chk_out({tag, ".holdn"});
      end
      @(negedge clk);
      stall_i = 1'b0; flush_i = hfl;
      mem_ack_i = 1'($urandom); mem_data_i = $urandom;
      step();
      if (!hfl) begin
        m_inst = d; m_addr = a; m_valid = 1'b1;
      end
      chk_ctl({tag, ".rel"}, 0, 0, 0, 0);
      chk_out({tag, ".rel"});
    end
    idle_cycle(tag);
  endtask

  initial begin
    m_inst = NOP; m_addr = '0; m_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk_ctl("reset", 0, 0, 0, 0);
    chk("reset.maddr", mem_addr_o, 32'h0);
    chk_out("reset");
    @(negedge clk);
    rst = 1'b0;

    fetch("t1", 32'h0, 1, 32'h00500093, 0, 0, 0);
    fetch("t2", 32'h104, 3, 32'hDEADBEE3, 0, 0, 0);
    fetch("t3", 32'h108, 3, 32'h11111111, 1, 0, 0);
    fetch("t3b", 32'h200, 1, 32'h22222222, 0, 0, 0);
    fetch("t3c", 32'h20C, 2, 32'h2A2A2A2A, 2, 0, 0);
    fetch("t4", 32'h300, 1, 32'h33333333, 0, 3, 0);
    fetch("t4b", 32'h304, 2, 32'h44444444, 0, 2, 1);
    fetch("t5", 32'h400, TO + 1, 32'h0, 0, 0, 0);
    fetch("t5b", 32'h404, TO + 1, 32'h0, 5, 0, 0);
    fetch("t6", 32'h102, 1, 32'h0, 0, 0, 0);
    fetch("t6b", 32'h000000F0, 1, 32'h55555555, 0, 0, 0);

    // stall_i blocks a new fetch in IDLE
    @(negedge clk);
    pc_i = 32'h500; ce_i = 1'b1; stall_i = 1'b1;
    step();
    chk_ctl("istall", 0, 0, 0, 0);
    chk_out("istall");

    // flush in IDLE kills the held instruction and starts nothing
    @(negedge clk);
    pc_i = 32'h600; ce_i = 1'b1; stall_i = 1'b0; flush_i = 1'b1;
    step();
    m_valid = 1'b0;
    chk_ctl("iflush", 0, 0, 0, 0);
    chk_out("iflush");
    idle_cycle("iflush");

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int lat, fl, st;
      bit hfl;
      a = $urandom & 32'h0000FFFF;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      lat = ($urandom_range(0, 7) == 0) ? TO + 1 : $urandom_range(1, 4);
      fl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      st = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      hfl = 1'($urandom);
      fetch("rnd", a, lat, $urandom, fl, st, hfl);
    end

    // reset in the middle of WAIT, then a late ack
    @(negedge clk);
    pc_i = 32'h700; ce_i = 1'b1;
    step();
    chk_ctl("rw.req", 1, 1, 0, 0);
    @(negedge clk);
    ce_i = 1'b0;
    step();
    @(negedge clk);
    rst = 1'b1;
    step();
    m_inst = NOP; m_addr = '0; m_valid = 1'b0;
    chk_ctl("rw.rst", 0, 0, 0, 0);
    chk("rw.maddr", mem_addr_o, 32'h0);
    chk_out("rw.rst");
    @(negedge clk);
    rst = 1'b0; mem_ack_i = 1'b1; mem_data_i = 32'hBADBAD00;
    step();
    chk_ctl("rw.late", 0, 0, 0, 0);
    chk_out("rw.late");
    idle_cycle("rw");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
